// File: rtl/seq_divider_nbit.sv
// seq_divider_nbit: iterative unsigned restoring divider, one quotient bit per clock; DIV_BY_ZERO_DET_EN enables the zero-divisor shortcut
module seq_divider_nbit #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [N-1:0] q, d, q_nx;
    logic [N:0] r, t, r_nx;
    logic [CW-1:0] cnt;
    logic ge, last, zero_div, dbz;
`ifdef DIV_BY_ZERO_DET_EN
    assign zero_div = divisor == '0;
`else
    assign zero_div = 1'b0;
`endif
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign div_by_zero = dbz;
    // one restoring step plus next-state selection
    always_comb begin
        t = (r << 1) | (N+1)'(q[N-1]);
        ge = t >= {1'b0, d};
        r_nx = ge ? t - {1'b0, d} : t;
        q_nx = {q[N-2:0], ge};
        last = cnt == '0;
        state_nx = state == IDLE ? (start ? (zero_div ? DONE : RUN) : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            d <= '0;
            r <= '0;
            cnt <= '0;
            quotient <= '0;
            remainder <= '0;
            dbz <= 1'b0;
        end else if (state == IDLE && start) begin
            q <= dividend;
            d <= divisor;
            r <= '0;
            cnt <= CW'(N-1);
            if (zero_div) begin
                quotient <= '1;
                remainder <= dividend;
                dbz <= 1'b1;
            end
        end else if (state == RUN) begin
            q <= q_nx;
            r <= r_nx;
            cnt <= cnt - 1'b1;
            if (last) begin
                quotient <= q_nx;
                remainder <= r_nx[N-1:0];
                dbz <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_nbit.sv
// tb_seq_divider_nbit: randomized self-checking bench for seq_divider_nbit against an arithmetic reference
module tb_seq_divider_nbit;
    localparam int N = 6;
    localparam int M = (1 << N) - 1;
`ifdef DIV_BY_ZERO_DET_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;
    int errors = 0, checks = 0;

    seq_divider_nbit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = M;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: q=%0d r=%0d dz=%b want 0 0 0", quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic do_op(input int a, input int b, input string name);
        int n, eq, er, lat;
        bit ez;
        model(a, b, eq, er);
        ez = ZD && (b == 0);
        lat = ez ? 0 : N;
        @(negedge clk);
        start = 1'b1;
        dividend = N'(a);
        divisor = N'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = N'($urandom);
        divisor = N'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        checks++;
        if (quotient !== N'(eq)) begin
            errors++;
            $display("FAIL %s quotient: got %0d want %0d", name, quotient, eq);
        end
        checks++;
        if (remainder !== N'(er)) begin
            errors++;
            $display("FAIL %s remainder: got %0d want %0d", name, remainder, er);
        end
        checks++;
        if (div_by_zero !== ez) begin
            errors++;
            $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, ez);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_basic();
        do_op(45, 7, "basic_45_7");
    endtask

    task automatic test_corners();
        int ta[4] = '{63, 5, 63, 0};
        int tb[4] = '{1, 9, 63, 5};
        for (int i = 0; i < 4; i++) do_op(ta[i], tb[i], $sformatf("corner_%0d_%0d", ta[i], tb[i]));
    endtask

    task automatic test_div_zero();
        do_op(20, 0, "div_zero_20");
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1;
        dividend = 6'd45;
        divisor = 6'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= N + 3; e++) begin
            start = (e == 3);
            dividend = (e == 3) ? 6'd50 : 6'd0;
            divisor = (e == 3) ? 6'd3 : 6'd0;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (e !== N || quotient !== 6'd6 || remainder !== 6'd3) begin
                    errors++;
                    $display("FAIL busy_start_result: edge=%0d q=%0d r=%0d want edge %0d q=6 r=3", e, quotient, remainder, N);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_start_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1;
        dividend = 6'd45;
        divisor = 6'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b q=%0d r=%0d dz=%b want all 0", busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < N + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses);
        end
        do_op(17, 4, "after_reset_17_4");
    endtask

    task automatic test_back_to_back();
        int ea = 0, eb = 0, eq, er, ops = 1000;
        bit exp_done;
        start = 1'b1;
        for (int k = 0; k < ops * (N + 2); k++) begin
            dividend = N'($urandom_range(0, M));
            divisor = N'($urandom_range(1, M));
            if (k % (N + 2) == 0) begin
                ea = int'(dividend);
                eb = int'(divisor);
            end
            @(posedge clk);
            @(negedge clk);
            exp_done = (k % (N + 2)) == N;
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done_k%0d: got %b want %b", k, done, exp_done);
            end
            if (exp_done) begin
                model(ea, eb, eq, er);
                checks++;
                if (quotient !== N'(eq) || remainder !== N'(er)) begin
                    errors++;
                    $display("FAIL b2b_result %0d/%0d: q=%0d r=%0d want q=%0d r=%0d", ea, eb, quotient, remainder, eq, er);
                end
                checks++;
                if (int'(quotient) * eb + int'(remainder) != ea || int'(remainder) >= eb) begin
                    errors++;
                    $display("FAIL b2b_identity %0d/%0d: q=%0d r=%0d", ea, eb, quotient, remainder);
                end
            end
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_idle: busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
